// File: rtl/namuru_regs_pkg.sv
// Shared definitions for the namuru correlator register map.
// Holds the register word indices, the clear-register bit positions, the
// accumulation fetcher state type and small address helpers. Both the
// correlator slave and the fetcher import this package so they agree on
// the register layout.
package namuru_regs_pkg;

    // Per-channel accumulation result registers (channel 0), word indices.
    localparam logic [7:0] REG_I_EARLY     = 8'h04;
    localparam logic [7:0] REG_Q_EARLY     = 8'h05;
    localparam logic [7:0] REG_I_PROMPT    = 8'h06;
    localparam logic [7:0] REG_Q_PROMPT    = 8'h07;
    localparam logic [7:0] REG_I_LATE      = 8'h08;
    localparam logic [7:0] REG_Q_LATE      = 8'h09;
    localparam logic [7:0] REG_CODE_MEAS   = 8'h0A;
    localparam logic [7:0] REG_CARR_MEAS   = 8'h0B;
    localparam logic [7:0] REG_EPOCH       = 8'h0C;
    localparam logic [7:0] REG_EPOCH_CHECK = 8'h0D;

    // Global status / control registers, word indices.
    localparam logic [7:0] REG_STATUS      = 8'hE0;
    localparam logic [7:0] REG_NEW_DATA    = 8'hE1;
    localparam logic [7:0] REG_CLEAR       = 8'hE4;
    localparam logic [7:0] REG_HWTAG       = 8'hEF;

    // Bit positions inside the clear register.
    localparam int CLR_STATUS_BIT   = 0;
    localparam int CLR_NEW_DATA_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_PUSH    = 3'd3,
        ST_WR_REQ  = 3'd4,
        ST_WR_WAIT = 3'd5
    } fetch_state_t;

    // Byte address of a register word index relative to the slave base.
    function automatic logic [31:0] reg_addr(input logic [31:0] base,
                                             input logic [7:0]  idx);
        return base + {22'b0, idx, 2'b00};
    endfunction

    // Next read index in the dump order: STATUS -> NEW_DATA -> 0x04..0x0D.
    // Only called when the current record is not the last one.
    function automatic logic [7:0] next_read_idx(input logic [7:0] idx);
        return (idx == REG_NEW_DATA) ? REG_I_EARLY : idx + 8'd1;
    endfunction

endpackage

// File: rtl/namuru_accum_fetcher_if.sv
// Wishbone classic bus bundle between the accumulation fetcher (master)
// and the correlator register slave.
//   wbm_adr_o  byte address          wbm_dat_o  write data
//   wbm_dat_i  read data             wbm_sel_o  byte selects
//   wbm_cyc_o  bus cycle             wbm_stb_o  strobe
//   wbm_we_o   write enable          wbm_ack_i  slave acknowledge
// Handshake: a transfer is presented with cyc=stb=1 and held unchanged
// until ack is sampled high; that edge completes it.
interface namuru_accum_fetcher_if;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic        wbm_ack_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/namuru_wbm_port.sv
// Single-transfer Wishbone classic master port with ack timeout.
//   clk, rstn  clock, synchronous active-low reset
//   start      pulse: latch adr/we/wdata and raise cyc/stb next cycle
//   done       combinational: ack sampled this cycle while stb is high
//   timeout    combinational: stb waited ACK_TIMEOUT cycles with no ack
//   rdata      read data, valid together with done
//   wb         Wishbone master modport
// cyc/stb/adr/we/dat_o are registered and drop on the edge that sees
// done or timeout, so stb is never high in the cycle after an ack.
module namuru_wbm_port #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic        timeout,
    output logic [31:0] rdata,
    namuru_accum_fetcher_if.master wb
);

    // The timer holds the number of no-ack cycles already spent, so the
    // abort fires in the ACK_TIMEOUT-th cycle of stb.
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    logic [7:0] timer;

    assign done    = wb.wbm_stb_o & wb.wbm_ack_i;
    assign timeout = wb.wbm_stb_o & ~wb.wbm_ack_i & (timer == TMO_LAST);
    assign rdata   = wb.wbm_dat_i;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wb.wbm_cyc_o <= 1'b0;
            wb.wbm_stb_o <= 1'b0;
            wb.wbm_we_o  <= 1'b0;
            wb.wbm_sel_o <= 4'h0;
            wb.wbm_adr_o <= 32'h0;
            wb.wbm_dat_o <= 32'h0;
            timer        <= 8'h0;
        end else if (start) begin
            wb.wbm_cyc_o <= 1'b1;
            wb.wbm_stb_o <= 1'b1;
            wb.wbm_we_o  <= we;
            wb.wbm_sel_o <= 4'hF;
            wb.wbm_adr_o <= adr;
            wb.wbm_dat_o <= wdata;
            timer        <= 8'h0;
        end else if (wb.wbm_stb_o) begin
            if (done || timeout) begin
                wb.wbm_cyc_o <= 1'b0;
                wb.wbm_stb_o <= 1'b0;
                wb.wbm_we_o  <= 1'b0;
                wb.wbm_sel_o <= 4'h0;
                wb.wbm_dat_o <= 32'h0;
                timer        <= 8'h0;
            end else begin
                timer <= timer + 8'd1;
            end
        end
    end

endmodule

// File: rtl/namuru_accum_fetcher.sv
// Accumulation dump fetcher for the namuru correlator.
// On a rising edge of accum_int it reads STATUS and NEW_DATA, then the ten
// channel-0 result registers if NEW_DATA bit0 is set, forwarding every
// word as a record, and finally writes the clear register.
//   correlator_clk, rstn      clock, synchronous active-low reset
//   enable                    gate for new triggers
//   accum_int                 level interrupt from the correlator
//   ovr_clr                   clears the overrun flag
//   wb                        Wishbone master bus
//   rec_valid/rec_ready       record stream handshake; a record transfers
//                             on an edge with both high and stays stable
//                             until then
//   rec_data/rec_idx/rec_last record payload, word index, end-of-dump mark
//   busy, err, ovr            status: sequence active, ack timeout, overrun
//   dbg_state                 current FSM state
module namuru_accum_fetcher
    import namuru_regs_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16,
    parameter logic [1:0]  CLEAR_MASK  = 2'b11
) (
    input  logic         correlator_clk,
    input  logic         rstn,
    input  logic         enable,
    input  logic         accum_int,
    input  logic         ovr_clr,
    namuru_accum_fetcher_if.master wb,
    output logic         rec_valid,
    input  logic         rec_ready,
    output logic [31:0]  rec_data,
    output logic [7:0]   rec_idx,
    output logic         rec_last,
    output logic         busy,
    output logic         err,
    output logic         ovr,
    output fetch_state_t dbg_state
);

    fetch_state_t state, next_state;
    logic [7:0]   cur_idx;
    logic [7:0]   start_idx;
    logic         start, start_we;
    logic [31:0]  start_wdata;
    logic [31:0]  clear_word;
    logic         new_data_q;
    logic         accum_q;
    logic         rise;
    logic         rd_done;
    logic         port_done, port_timeout;
    logic [31:0]  port_rdata;

    assign rise      = accum_int & ~accum_q;
    assign rec_valid = (state == ST_PUSH);
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;
    assign rd_done   = port_done & ((state == ST_RD_REQ) | (state == ST_RD_WAIT));

    always_comb begin
        clear_word                   = 32'h0;
        clear_word[CLR_STATUS_BIT]   = CLEAR_MASK[0];
        clear_word[CLR_NEW_DATA_BIT] = CLEAR_MASK[1];
    end

    assign start_wdata = start_we ? clear_word : 32'h0;

    namuru_wbm_port #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_port (
        .clk    (correlator_clk),
        .rstn   (rstn),
        .start  (start),
        .we     (start_we),
        .adr    (reg_addr(BASE_ADDR, start_idx)),
        .wdata  (start_wdata),
        .done   (port_done),
        .timeout(port_timeout),
        .rdata  (port_rdata),
        .wb     (wb)
    );

    // Requests are launched on the transition into RD_REQ/WR_REQ so that
    // stb is already high in those states.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        start_we   = 1'b0;
        start_idx  = cur_idx;
        case (state)
            ST_IDLE: begin
                if (rise && enable) begin
                    next_state = ST_RD_REQ;
                    start      = 1'b1;
                    start_idx  = REG_STATUS;
                end
            end
            ST_RD_REQ, ST_RD_WAIT: begin
                if (port_done)         next_state = ST_PUSH;
                else if (port_timeout) next_state = ST_IDLE;
                else                   next_state = ST_RD_WAIT;
            end
            ST_PUSH: begin
                if (rec_ready) begin
                    start = 1'b1;
                    if (rec_last) begin
                        next_state = ST_WR_REQ;
                        start_we   = 1'b1;
                        start_idx  = REG_CLEAR;
                    end else begin
                        next_state = ST_RD_REQ;
                        start_idx  = next_read_idx(cur_idx);
                    end
                end
            end
            ST_WR_REQ, ST_WR_WAIT: begin
                if (port_done || port_timeout) next_state = ST_IDLE;
                else                           next_state = ST_WR_WAIT;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge correlator_clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            cur_idx    <= 8'h0;
            new_data_q <= 1'b0;
            // Treat the interrupt as already high so a level present at
            // reset release is not mistaken for an edge.
            accum_q    <= 1'b1;
            rec_data   <= 32'h0;
            rec_idx    <= 8'h0;
            rec_last   <= 1'b0;
            err        <= 1'b0;
            ovr        <= 1'b0;
        end else begin
            state   <= next_state;
            accum_q <= accum_int;
            if (start) cur_idx <= start_idx;

            if (state == ST_IDLE && rise && enable) begin
                err        <= 1'b0;
                new_data_q <= 1'b0;
            end else if (port_timeout) begin
                err <= 1'b1;
            end

            if (rd_done) begin
                rec_data <= port_rdata;
                rec_idx  <= cur_idx;
                rec_last <= ((cur_idx == REG_NEW_DATA) && !port_rdata[0]) ||
                            (cur_idx == REG_EPOCH_CHECK);
                if (cur_idx == REG_NEW_DATA) new_data_q <= port_rdata[0];
            end

            // A set in the same cycle as a clear wins.
            if (rise && busy)  ovr <= 1'b1;
            else if (ovr_clr)  ovr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_namuru_accum_fetcher.sv
// Self-checking bench for namuru_accum_fetcher: Wishbone slave model,
// record scoreboard, table-driven dump sequences and hand-written corner
// cases (consumer stall, ack timeout, overrun, enable gate, mid-read reset).
module tb_namuru_accum_fetcher;
    import namuru_regs_pkg::*;

    localparam logic [31:0] BASE        = 32'h0001_0000;
    localparam logic [31:0] EXP_CLR_ADR = BASE + 32'h0000_0390;
    localparam logic [31:0] EXP_CLR_DAT = 32'h0000_0003;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn, enable, accum_int, ovr_clr, rec_ready;
    logic         rec_valid, rec_last, busy, err, ovr;
    logic [31:0]  rec_data;
    logic [7:0]   rec_idx;
    fetch_state_t dut_state;

    namuru_accum_fetcher_if wb();

    namuru_accum_fetcher #(
        .BASE_ADDR(BASE), .ACK_TIMEOUT(16), .CLEAR_MASK(2'b11)
    ) dut (
        .correlator_clk(clk), .rstn(rstn), .enable(enable),
        .accum_int(accum_int), .ovr_clr(ovr_clr), .wb(wb),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
        .rec_idx(rec_idx), .rec_last(rec_last), .busy(busy), .err(err),
        .ovr(ovr), .dbg_state(dut_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick_pos(); @(posedge clk); #1; endtask
    task automatic tick_neg(); @(negedge clk); #1; endtask

    // ---------------- slave model ----------------
    logic       slave_ack = 1'b0;
    int         wait_cnt  = 0;
    logic [7:0] noack_idx = 8'hFF;
    logic       slave_nd  = 1'b1;

    function automatic logic [31:0] rd_val(input logic [7:0] idx, input logic nd);
        if (idx == REG_NEW_DATA) return {31'b0, nd};
        return {idx, 8'h5A, ~idx, idx ^ 8'h3C};
    endfunction

    // Reads ack after 3 wait cycles, writes after 1.
    always @(posedge clk) begin
        if (wb.wbm_cyc_o && wb.wbm_stb_o && !slave_ack && wb.wbm_adr_o[9:2] != noack_idx) begin
            if (wait_cnt == (wb.wbm_we_o ? 0 : 2)) begin
                slave_ack <= 1'b1;
                wait_cnt  <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            slave_ack <= 1'b0;
            wait_cnt  <= 0;
        end
    end

    assign wb.wbm_ack_i = slave_ack;
    assign wb.wbm_dat_i = (wb.wbm_cyc_o && wb.wbm_stb_o && !wb.wbm_we_o) ?
                          rd_val(wb.wbm_adr_o[9:2], slave_nd) : 32'h0;

    // ---------------- scoreboard / monitors ----------------
    logic [40:0] exp_q[$];      // {last, idx, data}
    int          rd_cnt, data_rd_cnt, wr_cnt, busy_cycles;
    logic [31:0] last_wr_adr, last_wr_dat;
    int          bus_bad = 0, b2b_bad = 0, push_stb_bad = 0, stable_bad = 0;
    int          stb_run = 0, last_run = 0;
    logic        prev_ack = 1'b0, hold_pending = 1'b0;
    logic [40:0] held;

    task automatic push_seq(input logic nd);
        exp_q.push_back({1'b0, REG_STATUS, rd_val(REG_STATUS, nd)});
        exp_q.push_back({~nd, REG_NEW_DATA, rd_val(REG_NEW_DATA, nd)});
        if (nd) begin
            for (int i = 4; i <= 13; i++) begin
                logic [7:0] ix;
                ix = 8'(i);
                exp_q.push_back({(i == 13), ix, rd_val(ix, nd)});
            end
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (busy) busy_cycles++;
            if (wb.wbm_stb_o && wb.wbm_sel_o != 4'hF) bus_bad++;
            if (wb.wbm_stb_o != wb.wbm_cyc_o) bus_bad++;
            if (prev_ack && wb.wbm_stb_o) b2b_bad++;
            prev_ack = wb.wbm_stb_o && wb.wbm_ack_i;
            if (wb.wbm_stb_o && wb.wbm_ack_i) begin
                if (wb.wbm_we_o) begin
                    wr_cnt++;
                    last_wr_adr = wb.wbm_adr_o;
                    last_wr_dat = wb.wbm_dat_o;
                end else begin
                    rd_cnt++;
                    if (wb.wbm_adr_o[9:2] >= 8'h04 && wb.wbm_adr_o[9:2] <= 8'h0D) data_rd_cnt++;
                end
            end
            if (wb.wbm_stb_o) stb_run++;
            else if (stb_run > 0) begin
                last_run = stb_run;
                stb_run  = 0;
            end
            if (rec_valid && wb.wbm_stb_o) push_stb_bad++;
            if (hold_pending && rec_valid && ({rec_last, rec_idx, rec_data} != held)) stable_bad++;
            if (rec_valid && rec_ready) begin
                hold_pending = 1'b0;
                if (exp_q.size() == 0) chk("unexpected_record", {rec_last, rec_idx, rec_data}, 64'h0);
                else chk("record", {rec_last, rec_idx, rec_data}, exp_q.pop_front());
            end else if (rec_valid) begin
                hold_pending = 1'b1;
                held         = {rec_last, rec_idx, rec_data};
            end else begin
                hold_pending = 1'b0;
            end
        end else begin
            prev_ack     = 1'b0;
            hold_pending = 1'b0;
            stb_run      = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_counts();
        rd_cnt = 0; data_rd_cnt = 0; wr_cnt = 0; busy_cycles = 0;
        last_wr_adr = 32'h0; last_wr_dat = 32'h0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok = 0;
        for (int n = 0; n < budget; n++) begin
            tick_pos();
            if (!busy) begin ok = 1; break; end
        end
        chk(name, ok, 1'b1);
    endtask

    // Full dump: trigger, optionally random consumer stalls, then checks.
    task automatic run_seq(input logic nd, input logic rnd, input int exp_reads, input int exp_data_reads);
        bit seen_busy = 0, ok = 0;
        slave_nd = nd;
        clear_counts();
        push_seq(nd);
        tick_pos();
        accum_int = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            tick_pos();
            rec_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (busy) seen_busy = 1;
            if (seen_busy && !busy) begin ok = 1; break; end
        end
        accum_int = 1'b0;
        rec_ready = 1'b1;
        tick_neg();
        chk("seq_done", ok, 1'b1);
        chk("records_left", exp_q.size(), 0);
        chk("bus_reads", rd_cnt, exp_reads);
        chk("data_reads", data_rd_cnt, exp_data_reads);
        chk("clear_writes", wr_cnt, 1);
        chk("clear_adr", last_wr_adr, EXP_CLR_ADR);
        chk("clear_dat", last_wr_dat, EXP_CLR_DAT);
        chk("err_after_seq", err, 1'b0);
        chk("state_idle", 64'(dut_state), 64'(ST_IDLE));
    endtask

    typedef struct {
        logic nd;
        logic rnd;
        int   exp_reads;
        int   exp_data_reads;
    } seq_vec_t;

    seq_vec_t vecs[4];

    // ---------------- test ----------------
    initial begin
        logic        found;
        logic [40:0] snap;
        int          stall_bad, stall_stb;

        vecs[0] = '{nd: 1'b1, rnd: 1'b0, exp_reads: 12, exp_data_reads: 10};
        vecs[1] = '{nd: 1'b0, rnd: 1'b0, exp_reads: 2,  exp_data_reads: 0};
        vecs[2] = '{nd: 1'b1, rnd: 1'b1, exp_reads: 12, exp_data_reads: 10};
        vecs[3] = '{nd: 1'b0, rnd: 1'b1, exp_reads: 2,  exp_data_reads: 0};

        rstn = 1'b0; enable = 1'b1; accum_int = 1'b0; ovr_clr = 1'b0; rec_ready = 1'b1;
        clear_counts();
        repeat (4) tick_pos();
        tick_neg();
        chk("rst_rec_valid", rec_valid, 1'b0);
        chk("rst_rec_data", rec_data, 32'h0);
        chk("rst_rec_idx", rec_idx, 8'h0);
        chk("rst_rec_last", rec_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ovr", ovr, 1'b0);
        chk("rst_cyc_stb", {wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o}, 3'b000);
        chk("rst_adr", wb.wbm_adr_o, 32'h0);
        chk("rst_sel", wb.wbm_sel_o, 4'h0);
        chk("rst_state", 64'(dut_state), 64'(ST_IDLE));
        tick_pos();
        rstn = 1'b1;
        repeat (2) tick_pos();

        // Table-driven dumps.
        foreach (vecs[i]) run_seq(vecs[i].nd, vecs[i].rnd, vecs[i].exp_reads, vecs[i].exp_data_reads);

        // Consumer stall on idx 06.
        clear_counts();
        slave_nd = 1'b1;
        push_seq(1'b1);
        tick_pos();
        accum_int = 1'b1;
        found = 0;
        for (int n = 0; n < 400; n++) begin
            tick_neg();
            if (wb.wbm_stb_o && wb.wbm_adr_o[9:2] == 8'h06) begin found = 1; break; end
        end
        chk("stall_read06_seen", found, 1'b1);
        tick_pos();
        rec_ready = 1'b0;
        found = 0;
        for (int n = 0; n < 20; n++) begin
            tick_neg();
            if (rec_valid) begin found = 1; break; end
        end
        chk("stall_valid", found, 1'b1);
        chk("stall_idx", rec_idx, 8'h06);
        snap = {rec_last, rec_idx, rec_data};
        stall_bad = 0; stall_stb = 0;
        for (int n = 0; n < 20; n++) begin
            tick_neg();
            if ({rec_last, rec_idx, rec_data} != snap || !rec_valid) stall_bad++;
            if (wb.wbm_stb_o) stall_stb++;
        end
        chk("stall_record_stable", stall_bad, 0);
        chk("stall_stb_low", stall_stb, 0);
        tick_pos();
        rec_ready = 1'b1;
        tick_neg();
        chk("stb_before_accept", wb.wbm_stb_o, 1'b0);
        tick_neg();
        chk("stb_after_accept", wb.wbm_stb_o, 1'b1);
        chk("adr_after_accept", wb.wbm_adr_o, BASE + 32'h1C);
        wait_idle("stall_idle", 400);
        accum_int = 1'b0;
        tick_neg();
        chk("stall_records_left", exp_q.size(), 0);
        chk("stall_clear_writes", wr_cnt, 1);

        // Ack timeout on NEW_DATA read.
        clear_counts();
        noack_idx = REG_NEW_DATA;
        exp_q.push_back({1'b0, REG_STATUS, rd_val(REG_STATUS, 1'b1)});
        tick_pos();
        accum_int = 1'b1;
        repeat (2) tick_pos();
        wait_idle("tmo_idle", 200);
        tick_neg();
        chk("tmo_err", err, 1'b1);
        chk("tmo_stb_cycles", last_run, 16);
        chk("tmo_no_clear", wr_cnt, 0);
        chk("tmo_busy", busy, 1'b0);
        chk("tmo_rec_valid", rec_valid, 1'b0);
        chk("tmo_records_left", exp_q.size(), 0);
        noack_idx = 8'hFF;
        accum_int = 1'b0;
        run_seq(1'b1, 1'b0, 12, 10);

        // Overrun: rise while busy, together with ovr_clr (set wins).
        clear_counts();
        slave_nd = 1'b1;
        push_seq(1'b1);
        tick_pos();
        accum_int = 1'b1;
        repeat (6) tick_pos();
        accum_int = 1'b0;
        tick_pos();
        accum_int = 1'b1;
        ovr_clr = 1'b1;
        tick_pos();
        ovr_clr = 1'b0;
        chk("ovr_set", ovr, 1'b1);
        wait_idle("ovr_idle", 400);
        tick_neg();
        chk("ovr_records_left", exp_q.size(), 0);
        chk("ovr_clear_writes", wr_cnt, 1);
        chk("ovr_sticky", ovr, 1'b1);
        tick_pos();
        ovr_clr = 1'b1;
        tick_pos();
        ovr_clr = 1'b0;
        chk("ovr_cleared", ovr, 1'b0);
        busy_cycles = 0;
        repeat (40) tick_pos();
        chk("level_no_retrigger", busy_cycles, 0);
        accum_int = 1'b0;
        tick_pos();

        // Disabled triggers are ignored.
        enable = 1'b0;
        accum_int = 1'b1;
        busy_cycles = 0;
        repeat (20) tick_pos();
        chk("disabled_no_seq", busy_cycles, 0);
        chk("disabled_no_ovr", ovr, 1'b0);
        accum_int = 1'b0;
        enable = 1'b1;
        tick_pos();

        // Reset in the middle of the idx 09 read.
        clear_counts();
        push_seq(1'b1);
        tick_pos();
        accum_int = 1'b1;
        found = 0;
        for (int n = 0; n < 400; n++) begin
            tick_neg();
            if (wb.wbm_stb_o && wb.wbm_adr_o[9:2] == 8'h09) begin found = 1; break; end
        end
        chk("rst_read09_seen", found, 1'b1);
        tick_pos();
        rstn = 1'b0;
        exp_q.delete();
        tick_pos();
        chk("midrst_bus", {wb.wbm_cyc_o, wb.wbm_stb_o}, 2'b00);
        chk("midrst_rec_valid", rec_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        repeat (2) tick_pos();
        rstn = 1'b1;
        busy_cycles = 0;
        repeat (30) tick_pos();
        chk("held_level_after_reset", busy_cycles, 0);
        accum_int = 1'b0;
        tick_pos();
        run_seq(1'b1, 1'b0, 12, 10);

        chk("bus_protocol", bus_bad, 0);
        chk("idle_after_ack", b2b_bad, 0);
        chk("no_bus_during_push", push_stb_bad, 0);
        chk("record_stability", stable_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
